mac_result_drain: RTL
=====================

// Module: mac_result_drain
// PURPOSE
// Reader/drain side of the matrix-vector MAC array. Snapshots the DEPTH parallel
// accumulator results when the compute engine signals completion, then serializes
// them as a byte stream over a valid/ready handshake toward host/UART/memory logic.
// Decouples the parallel c_vector bus from the narrow output path; reports busy and overrun.
// PARAMETERS
// DEPTH         8   number of result lanes (MAC count)
// RESULT_WIDTH  24  width of each accumulator result
// OUT_WIDTH     8   output beat width; RESULT_WIDTH must be an integer multiple
// PORTS
// clk        in   1                       single clock, rising edge
// rst_n      in   1                       asynchronous, active-low reset
// done       in   1                       1-cycle pulse: c_vector valid this cycle
// c_vector   in   RESULT_WIDTH x DEPTH    parallel MAC results, lane 0..DEPTH-1
// out_data   out  OUT_WIDTH               current output beat
// out_valid  out  1                       out_data valid
// out_ready  in   1                       downstream accepts beat
// out_last   out  1                       high with final beat of a frame
// busy       out  1                       snapshot held / frame in progress
// overrun    out  1                       sticky: done arrived while busy
// clr_err    in   1                       synchronous clear of overrun
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; out_valid=0, out_last=0, busy=0,
//   overrun=0, out_data=0, beat/lane counters=0, snapshot regs=0.
// - BEATS = RESULT_WIDTH/OUT_WIDTH (3 by default); frame = DEPTH*BEATS beats (24).
// - FSM: IDLE -> SEND on done; SEND -> IDLE after last beat handshake.
//   IDLE: busy=0, out_valid=0. done=1 at edge N latches all c_vector lanes into
//   snapshot regs; busy and out_valid high from cycle N+1 (1-cycle latency).
//   SEND: out_data = snapshot[lane][beat*OUT_WIDTH +: OUT_WIDTH]; lane 0 first,
//   least-significant beat first within a lane.
// - Handshake: beat transfers on edge with out_valid&out_ready. out_data/out_last
//   stable while out_valid&!out_ready. out_valid never drops without transfer.
//   Back-to-back beats allowed (1 beat/cycle at out_ready=1 continuously).
// - Counters: beat increments per transfer, wraps BEATS-1->0 and advances lane.
//   out_last=1 only when lane=DEPTH-1 and beat=BEATS-1.
// - Last-beat transfer: next cycle busy=0, out_valid=0, counters=0, state IDLE.
//   done on the same edge as last-beat transfer counts as busy: ignored, overrun set.
// - done while busy: snapshot not overwritten, frame unaffected, overrun<=1.
// - clr_err clears overrun; if clr_err and an overrun event coincide, overrun=1.
// - Snapshot regs only written on accepted done; c_vector changes otherwise ignored.
// - rst_n low mid-frame aborts immediately; no partial-frame resume.
// TESTING
// 1 Reset: rst_n=0 -> out_valid=0, busy=0, overrun=0, out_data=0; after release idle.
// 2 Lane k=k*0x010203+0x000001, done pulse, out_ready=1 -> 24 beats in 24 cycles,
//   first 0x01,0x00,0x00 then 0x04,0x02,0x01; out_last on beat 24 only; busy drops.
// 3 Same frame, out_ready toggled 1,0,0,1 pseudo-random -> out_data stable while stalled,
//   byte order identical to test 2, no beat dropped or duplicated.
// 4 done again on beat 5 with different c_vector -> frame data unchanged,
//   overrun=1; clr_err pulse -> overrun=0; new done after frame accepted normally.
// 5 All lanes 0xFFFFFF -> 24 beats of 0xFF; c_vector changed mid-frame has no effect.
// 6 rst_n asserted on beat 10 -> outputs zero asynchronously; new done after release
//   streams full 24-beat frame from lane 0 beat 0.

Source files
------------

// File: rtl/mac_result_drain.sv
// mac_result_drain: snapshots parallel MAC results on done and streams them out as valid/ready beats
module mac_result_drain #(
  parameter int DEPTH        = 8,
  parameter int RESULT_WIDTH = 24,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          done_i,
  input  logic [DEPTH*RESULT_WIDTH-1:0] c_vector_i,
  output logic [OUT_WIDTH-1:0]          out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_last_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  input  logic                          clr_err_i
);
  localparam int BEATS = RESULT_WIDTH / OUT_WIDTH;
  localparam int BW = $clog2(BEATS > 1 ? BEATS : 2);
  localparam int LW = $clog2(DEPTH > 1 ? DEPTH : 2);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BEATS - 1);
  localparam logic [LW-1:0] LANE_MAX = LW'(DEPTH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] lane_q, lane_d;
  logic overrun_q, overrun_d;
  logic [RESULT_WIDTH-1:0] snap_q [DEPTH];
  logic xfer, last_beat, load;
  assign xfer = state_q == SEND && out_ready_i;
  assign last_beat = lane_q == LANE_MAX && beat_q == BEAT_MAX;
  assign load = state_q == IDLE && done_i;
  // state, beat/lane counters and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      lane_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      lane_q    <= lane_d;
      overrun_q <= overrun_d;
    end
  end
  // snapshot is captured only when done is accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) snap_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < DEPTH; k++) snap_q[k] <= c_vector_i[k*RESULT_WIDTH +: RESULT_WIDTH];
    end
  end
  // next state: counters step per transfer and return to zero after the final beat
  always_comb begin
    state_d   = state_q == IDLE ? (done_i ? SEND : IDLE) : (xfer && last_beat ? IDLE : SEND);
    beat_d    = !xfer ? beat_q : (beat_q == BEAT_MAX ? '0 : beat_q + 1'b1);
    lane_d    = (!xfer || beat_q != BEAT_MAX) ? lane_q : (last_beat ? '0 : lane_q + 1'b1);
    overrun_d = (done_i && state_q == SEND) || (overrun_q && !clr_err_i);
  end
  // outputs: data is a pure function of the held snapshot and counters, so it is stable while stalled
  always_comb begin
    busy_o      = state_q == SEND;
    out_valid_o = state_q == SEND;
    out_last_o  = state_q == SEND && last_beat;
    out_data_o  = state_q == SEND ? snap_q[lane_q][beat_q*OUT_WIDTH +: OUT_WIDTH] : '0;
    overrun_o   = overrun_q;
  end
endmodule
